// File: rtl/cordic_vectoring_iterative_if.sv
// cordic_vectoring_iterative_if: valid/ready input and output channels of the vectoring CORDIC
interface cordic_vectoring_iterative_if;
  logic signed [21:0] x_in;
  logic signed [21:0] y_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [21:0] angle_out;
  logic signed [21:0] mag_out;
  logic               out_valid;
  logic               out_ready;
  modport master (output x_in, y_in, in_valid, out_ready, input in_ready, angle_out, mag_out, out_valid);
  modport slave (input x_in, y_in, in_valid, out_ready, output in_ready, angle_out, mag_out, out_valid);
endinterface

// File: rtl/cordic_vectoring_iterative.sv
// cordic_vectoring_iterative: iterative atan2/magnitude CORDIC in Q3.19 with valid/ready handshakes
module cordic_vectoring_iterative #(
  parameter int ITERATIONS = 17
) (
  input logic                        clk,
  input logic                        reset,
  input logic                        enable,
  cordic_vectoring_iterative_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREROT, ITER, SCALE, DONE} state_t;
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);
  localparam logic signed [24:0] PI_2 = 25'sd823550;
  localparam logic [21:0] ATAN [32] = '{
    22'd411775, 22'd243085, 22'd128439, 22'd65198, 22'd32725, 22'd16379, 22'd8191, 22'd4096,
    22'd2048, 22'd1024, 22'd512, 22'd256, 22'd128, 22'd64, 22'd32, 22'd16,
    22'd8, 22'd4, 22'd2, 22'd1, 22'd0, 22'd0, 22'd0, 22'd0,
    22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0};
  state_t r_state, w_next;
  logic signed [24:0] r_x, r_y, r_z;
  logic        [4:0]  r_cnt;
  logic signed [21:0] r_angle, r_mag;
  logic signed [24:0] w_dx, w_dy, w_atan;
  logic signed [44:0] w_prod, w_mag;
  logic signed [21:0] w_sat;
  logic               w_zero;
  assign w_dx   = r_y >>> r_cnt;
  assign w_dy   = r_x >>> r_cnt;
  assign w_atan = {3'b000, ATAN[r_cnt]};
  // Gain compensation by K^-1 in Q0.19, rounded, then clamped into the 22-bit output range
  assign w_prod = 45'(r_x) * 45'sd318375;
  assign w_mag  = (w_prod + 45'sd262144) >>> 19;
  assign w_sat  = w_mag > 45'sd2097151 ? 22'sh1FFFFF : w_mag < 0 ? '0 : w_mag[21:0];
  assign w_zero = r_x == '0 && r_y == '0;
  assign bus.in_ready  = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.angle_out = r_angle;
  assign bus.mag_out   = r_mag;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.in_valid ? PREROT : IDLE;
      PREROT:  w_next = ITER;
      ITER:    w_next = r_cnt == LAST ? SCALE : ITER;
      SCALE:   w_next = DONE;
      DONE:    w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else if (enable) r_state <= w_next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_angle <= '0;
      r_mag   <= '0;
    end else if (enable) begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_x <= {{3{bus.x_in[21]}}, bus.x_in};
          r_y <= {{3{bus.y_in[21]}}, bus.y_in};
        end
        // Fold the left half-plane into the right so the iterations converge; y = 0 folds to +pi
        PREROT: begin
          if (r_x < 0 && r_y >= 0) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= PI_2;
          end else if (r_x < 0) begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -PI_2;
          end else r_z <= '0;
          r_cnt <= '0;
        end
        ITER: begin
          r_x   <= r_y[24] ? r_x - w_dx : r_x + w_dx;
          r_y   <= r_y[24] ? r_y + w_dy : r_y - w_dy;
          r_z   <= r_y[24] ? r_z - w_atan : r_z + w_atan;
          r_cnt <= r_cnt + 5'd1;
        end
        SCALE: begin
          r_angle <= w_zero ? '0 : r_z[21:0];
          r_mag   <= w_zero ? '0 : w_sat;
        end
        default: ;
      endcase
    end
  end
endmodule
